// File: rtl/axis_trigger_stamper_pkg.sv
// Shared types and width helpers for the trigger timestamper.
package axis_trigger_stamper_pkg;

    localparam int DIN_WIDTH_DEF       = 66;
    localparam int TIME_WIDTH_DEF      = 62;
    localparam int FIFO_ADDR_WIDTH_DEF = 4;
    localparam int HOLDOFF_WIDTH_DEF   = 16;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } mode_e;

    // Event word at the default widths; instances with other widths build the same layout locally.
    typedef struct packed {
        logic [TIME_WIDTH_DEF-1:0] ts;
        logic [DIN_WIDTH_DEF-1:0]  data;
    } event_word_t;

    function automatic int tdata_width(input int din_w, input int time_w);
        return din_w + time_w;
    endfunction

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/axis_trigger_stamper_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module axis_trigger_stamper_fifo
    import axis_trigger_stamper_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_trigger_stamper.sv
// Trigger timestamper: masked level/edge detection with holdoff, stamped events streamed out over AXI4-Stream.
// Optional lost-event counter enabled by defining AXIS_TRIGGER_STAMPER_LOST_COUNT_EN.
module axis_trigger_stamper
    import axis_trigger_stamper_pkg::*;
#(
    parameter int DIN_WIDTH       = DIN_WIDTH_DEF,
    parameter int TIME_WIDTH      = TIME_WIDTH_DEF,
    parameter int FIFO_ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
    parameter int HOLDOFF_WIDTH   = HOLDOFF_WIDTH_DEF
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [DIN_WIDTH-1:0]            din,
    input  logic [DIN_WIDTH-1:0]            cfg_mask,
    input  logic                            cfg_edge,
    input  logic [HOLDOFF_WIDTH-1:0]        cfg_holdoff,
    input  logic                            cfg_clear,
    output logic [TIME_WIDTH+DIN_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            overflow,
    output logic [1:0]                      test
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
    ,
    output logic [31:0]                     lost_count
`endif
);

    localparam int TDATA_W = tdata_width(DIN_WIDTH, TIME_WIDTH);

    typedef struct packed {
        logic [TIME_WIDTH-1:0] ts;
        logic [DIN_WIDTH-1:0]  data;
    } evt_t;

    logic [TIME_WIDTH-1:0]    time_cnt;
    logic [TIME_WIDTH-1:0]    time_p1;
    logic [DIN_WIDTH-1:0]     din_p1;
    logic [DIN_WIDTH-1:0]     din_prev_p1;
    logic [DIN_WIDTH-1:0]     hit_vec;
    logic [HOLDOFF_WIDTH-1:0] holdoff_cnt;
    mode_e                    mode;
    logic                     hit;
    logic                     pop;
    logic                     drop;
    logic                     fifo_full;
    logic                     fifo_empty;
    evt_t                     push_word;

    // Stage 1: sample the trigger bus and the free-running time counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            time_cnt    <= '0;
            time_p1     <= '0;
            din_p1      <= '0;
            din_prev_p1 <= '0;
        end else begin
            time_cnt    <= time_cnt + TIME_WIDTH'(1);
            time_p1     <= time_cnt;
            din_p1      <= din;
            din_prev_p1 <= din_p1;
        end
    end

    assign mode = mode_e'(cfg_edge);

    always_comb begin
        hit_vec = din_p1 & cfg_mask;
        if (mode == MODE_EDGE) begin
            hit_vec = hit_vec & ~din_prev_p1;
        end
    end

    assign hit = (|hit_vec) && (holdoff_cnt == '0);

    // Dropped hits also open a holdoff window, so the load does not depend on FIFO space.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            holdoff_cnt <= '0;
        end else if (hit) begin
            holdoff_cnt <= cfg_holdoff;
        end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - HOLDOFF_WIDTH'(1);
        end
    end

    // Stage 2: push the stamped event; the FIFO head drives the stream.
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign drop      = hit && fifo_full && !pop;
    assign push_word = '{ts: time_p1, data: din_p1};

    axis_trigger_stamper_fifo #(
        .WIDTH      (TDATA_W),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (hit),
        .push_data (push_word),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .rd_data   (m_axis_tdata)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign test          = {fifo_full, hit};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (cfg_clear) begin
            overflow <= 1'b0;
        end
    end

`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A drop coincident with a clear counts as the first loss after the clear.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lost_count <= '0;
        end else if (drop) begin
            lost_count <= cfg_clear ? 32'd1 : sat_inc32(lost_count);
        end else if (cfg_clear) begin
            lost_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_axis_trigger_stamper.sv
// Directed bench for axis_trigger_stamper with 8-bit bus, 8-bit timestamps and a 4-entry FIFO.
module tb_axis_trigger_stamper;

    localparam int DW = 8;
    localparam int TW = 8;
    localparam int AW = 2;
    localparam int HW = 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] din;
    logic [DW-1:0] cfg_mask;
    logic          cfg_edge;
    logic [HW-1:0] cfg_holdoff;
    logic          cfg_clear;
    logic [TW+DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          overflow;
    logic [1:0]    test;
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
    logic [31:0]   lost_count;
`endif

    always #5 aclk = ~aclk;

    axis_trigger_stamper #(
        .DIN_WIDTH       (DW),
        .TIME_WIDTH      (TW),
        .FIFO_ADDR_WIDTH (AW),
        .HOLDOFF_WIDTH   (HW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .din           (din),
        .cfg_mask      (cfg_mask),
        .cfg_edge      (cfg_edge),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_clear     (cfg_clear),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .test          (test)
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
        ,
        .lost_count    (lost_count)
`endif
    );

    // Reference cycle count: equals the value a sample taken at the next edge will carry.
    logic [TW-1:0] cyc;
    always @(posedge aclk) begin
        if (!aresetn) cyc <= '0;
        else          cyc <= cyc + 8'd1;
    end

    logic [TW+DW-1:0] rx_q[$];
    always @(posedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; din = '0; cfg_mask = '1; cfg_edge = 1'b0;
        cfg_holdoff = '0; cfg_clear = 1'b0; m_axis_tready = 1'b1;
        tick(2);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++; if (test !== 2'b00) begin n_miss++; $display("FAIL reset_test: got %b want 00", test); end
        n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
        n_vec++; if (lost_count !== 32'd0) begin n_miss++; $display("FAIL reset_lost: got %0d want 0", lost_count); end
`endif
        aresetn = 1'b1;
    endtask

    task automatic test_level();
        logic [7:0] c0;
        rx_q.delete();
        c0 = cyc;
        n_vec++; if (c0 !== 8'd0) begin n_miss++; $display("FAIL level_t0: got %0d want 0", c0); end
        din = 8'h01;
        tick(1);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL level_lat1: tvalid got %b want 0", m_axis_tvalid); end
        tick(1);
        n_vec++; if (m_axis_tvalid !== 1'b1) begin n_miss++; $display("FAIL level_lat2: tvalid got %b want 1", m_axis_tvalid); end
        n_vec++; if (m_axis_tdata !== {c0, 8'h01}) begin n_miss++; $display("FAIL level_first: got %h want %h", m_axis_tdata, {c0, 8'h01}); end
        tick(1);
        din = 8'h00;
        tick(6);
        n_vec++; if (rx_q.size() !== 3) begin n_miss++; $display("FAIL level_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== {c0 + 8'(i), 8'h01}) begin n_miss++; $display("FAIL level_word%0d: got %h want %h", i, rx_q[i], {c0 + 8'(i), 8'h01}); end
        end
    endtask

    task automatic test_edge();
        logic [7:0] c0, c1;
        cfg_edge = 1'b1; din = 8'h00;
        tick(2);
        rx_q.delete();
        c0 = cyc; din = 8'h05;
        tick(10);
        n_vec++; if (rx_q.size() !== 1) begin n_miss++; $display("FAIL edge_one: got %0d words want 1", rx_q.size()); end
        n_vec++; if (rx_q.size() > 0 && rx_q[0] !== {c0, 8'h05}) begin n_miss++; $display("FAIL edge_word0: got %h want %h", rx_q[0], {c0, 8'h05}); end
        c1 = cyc; din = 8'h07;
        tick(5);
        n_vec++; if (rx_q.size() !== 2) begin n_miss++; $display("FAIL edge_two: got %0d words want 2", rx_q.size()); end
        n_vec++; if (rx_q.size() > 1 && rx_q[1] !== {c1, 8'h07}) begin n_miss++; $display("FAIL edge_word1: got %h want %h", rx_q[1], {c1, 8'h07}); end
        cfg_mask = 8'h04;
        for (int i = 0; i < 8; i++) begin
            din = (i % 2 == 0) ? 8'h04 : 8'h05;
            tick(1);
        end
        tick(4);
        n_vec++; if (rx_q.size() !== 2) begin n_miss++; $display("FAIL edge_masked: got %0d words want 2", rx_q.size()); end
        din = 8'h00; cfg_mask = 8'hFF;
        tick(2);
        cfg_edge = 1'b0;
    endtask

    task automatic test_holdoff();
        logic [7:0] c0;
        rx_q.delete();
        cfg_holdoff = 8'd4; c0 = cyc; din = 8'h01;
        tick(11);
        din = 8'h00;
        tick(8);
        cfg_holdoff = 8'd0;
        n_vec++; if (rx_q.size() !== 3) begin n_miss++; $display("FAIL holdoff_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== {c0 + 8'(5 * i), 8'h01}) begin n_miss++; $display("FAIL holdoff_word%0d: got %h want %h", i, rx_q[i], {c0 + 8'(5 * i), 8'h01}); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] c0;
        rx_q.delete();
        m_axis_tready = 1'b0; c0 = cyc;
        for (int i = 1; i <= 6; i++) begin
            din = 8'(i);
            tick(1);
        end
        din = 8'h00;
        tick(3);
        n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_vec++; if (test !== 2'b10) begin n_miss++; $display("FAIL ovf_test: got %b want 10", test); end
        n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {c0, 8'h01}) begin n_miss++; $display("FAIL ovf_head: got %b/%h want 1/%h", m_axis_tvalid, m_axis_tdata, {c0, 8'h01}); end
        tick(3);
        n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {c0, 8'h01}) begin n_miss++; $display("FAIL ovf_stable: got %b/%h want 1/%h", m_axis_tvalid, m_axis_tdata, {c0, 8'h01}); end
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
        n_vec++; if (lost_count !== 32'd2) begin n_miss++; $display("FAIL ovf_lost: got %0d want 2", lost_count); end
`endif
        m_axis_tready = 1'b1;
        tick(6);
        n_vec++; if (rx_q.size() !== 4) begin n_miss++; $display("FAIL ovf_drain: got %0d want 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== {c0 + 8'(i), 8'(i + 1)}) begin n_miss++; $display("FAIL ovf_word%0d: got %h want %h", i, rx_q[i], {c0 + 8'(i), 8'(i + 1)}); end
        end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL ovf_empty: tvalid got %b want 0", m_axis_tvalid); end
        n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        cfg_clear = 1'b1;
        tick(1);
        cfg_clear = 1'b0;
        n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL ovf_clear: got %b want 0", overflow); end
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
        n_vec++; if (lost_count !== 32'd0) begin n_miss++; $display("FAIL ovf_lost_clear: got %0d want 0", lost_count); end
`endif
    endtask

    task automatic test_full_simul();
        logic [7:0] c1;
        rx_q.delete();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(i);
            tick(1);
        end
        din = 8'h00;
        tick(3);
        n_vec++; if (test[1] !== 1'b1) begin n_miss++; $display("FAIL simul_full: got %b want 1", test[1]); end
        c1 = cyc; din = 8'h09;
        tick(1);
        din = 8'h00; m_axis_tready = 1'b1;
        tick(1);
        n_vec++; if (overflow !== 1'b0) begin n_miss++; $display("FAIL simul_noovf: got %b want 0", overflow); end
        tick(6);
        n_vec++; if (rx_q.size() !== 5) begin n_miss++; $display("FAIL simul_count: got %0d want 5", rx_q.size()); end
        n_vec++; if (rx_q.size() > 4 && rx_q[4] !== {c1, 8'h09}) begin n_miss++; $display("FAIL simul_last: got %h want %h", rx_q[4], {c1, 8'h09}); end
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
        n_vec++; if (lost_count !== 32'd0) begin n_miss++; $display("FAIL simul_lost: got %0d want 0", lost_count); end
`endif
    endtask

    task automatic test_clear_drop();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            din = 8'(i);
            tick(1);
        end
        din = 8'h00;
        tick(2);
        din = 8'h0B;
        tick(1);
        din = 8'h00;
        tick(2);
        n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("FAIL clr_pre: got %b want 1", overflow); end
        din = 8'h0A;
        tick(1);
        din = 8'h00; cfg_clear = 1'b1;
        tick(1);
        cfg_clear = 1'b0;
        n_vec++; if (overflow !== 1'b1) begin n_miss++; $display("FAIL clr_setwins: got %b want 1", overflow); end
`ifdef AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
        n_vec++; if (lost_count !== 32'd1) begin n_miss++; $display("FAIL clr_lost: got %0d want 1", lost_count); end
`endif
        m_axis_tready = 1'b1;
        tick(6);
        cfg_clear = 1'b1;
        tick(1);
        cfg_clear = 1'b0;
    endtask

    task automatic test_wrap();
        logic [7:0] c0;
        rx_q.delete();
        c0 = cyc;
        for (int k = 0; k < 300; k++) begin
            din = (k % 20 == 0) ? 8'h01 : 8'h00;
            tick(1);
        end
        din = 8'h00;
        tick(4);
        n_vec++; if (rx_q.size() !== 15) begin n_miss++; $display("FAIL wrap_count: got %0d want 15", rx_q.size()); end
        for (int i = 0; i < 15 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== {c0 + 8'(20 * i), 8'h01}) begin n_miss++; $display("FAIL wrap_word%0d: got %h want %h", i, rx_q[i], {c0 + 8'(20 * i), 8'h01}); end
        end
        rx_q.delete();
        for (int i = 0; i < 300 && cyc != 8'd254; i++) tick(1);
        n_vec++; if (cyc !== 8'd254) begin n_miss++; $display("FAIL wrap_wait: cycle got %0d want 254", cyc); end
        din = 8'h03;
        tick(3);
        din = 8'h00;
        tick(5);
        n_vec++; if (rx_q.size() !== 3) begin n_miss++; $display("FAIL wrap_edge_count: got %0d want 3", rx_q.size()); end
        n_vec++; if (rx_q.size() > 1 && rx_q[1] !== 16'hFF03) begin n_miss++; $display("FAIL wrap_255: got %h want ff03", rx_q[1]); end
        n_vec++; if (rx_q.size() > 2 && rx_q[2] !== 16'h0003) begin n_miss++; $display("FAIL wrap_0: got %h want 0003", rx_q[2]); end
    endtask

    task automatic test_mid_reset();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            din = 8'(i);
            tick(1);
        end
        din = 8'h00;
        tick(2);
        n_vec++; if (m_axis_tvalid !== 1'b1) begin n_miss++; $display("FAIL mrst_buffered: tvalid got %b want 1", m_axis_tvalid); end
        cfg_edge = 1'b1; din = 8'h01; aresetn = 1'b0;
        tick(1);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_miss++; $display("FAIL mrst_tvalid: got %b want 0", m_axis_tvalid); end
        n_vec++; if (test !== 2'b00) begin n_miss++; $display("FAIL mrst_test: got %b want 00", test); end
        aresetn = 1'b1; m_axis_tready = 1'b1;
        rx_q.delete();
        tick(6);
        n_vec++; if (rx_q.size() !== 1) begin n_miss++; $display("FAIL mrst_count: got %0d want 1", rx_q.size()); end
        n_vec++; if (rx_q.size() > 0 && rx_q[0] !== 16'h0001) begin n_miss++; $display("FAIL mrst_stamp0: got %h want 0001", rx_q[0]); end
        din = 8'h00;
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_holdoff();
        test_overflow();
        test_full_simul();
        test_clear_drop();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/axis_trigger_stamper.md
Name: axis_trigger_stamper

Overview:
Parametrised successor of the free-running trigger timestamper. It samples a DIN_WIDTH-bit trigger bus and detects masked events in level or rising-edge mode. An optional holdoff window suppresses re-triggers. Each accepted event is stamped with a TIME_WIDTH-bit cycle counter and buffered in a FIFO behind a full AXI4-Stream master with tready back-pressure. It sits between the trigger/discriminator logic and the DMA/packetiser.

Parameters:
DIN_WIDTH, 66, trigger bus width (1..128)
TIME_WIDTH, 62, timestamp counter width (8..64)
FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH entries
HOLDOFF_WIDTH, 16, width of holdoff configuration and counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
din  in  DIN_WIDTH  trigger inputs, already synchronous to aclk
cfg_mask  in  DIN_WIDTH  per-bit enable, 1 = bit may trigger
cfg_edge  in  1  0 = level mode, 1 = rising-edge mode
cfg_holdoff  in  HOLDOFF_WIDTH  cycles suppressed after an accepted event; 0 = none
cfg_clear  in  1  single-cycle pulse, clears overflow flag (and lost counter)
m_axis_tdata  out  TIME_WIDTH+DIN_WIDTH  {timestamp, captured din}
m_axis_tvalid  out  1  FIFO non-empty
m_axis_tready  in  1  downstream ready
overflow  out  1  sticky, event dropped because FIFO full
test  out  2  {fifo_full, hit}

Behaviour:
- Reset (aresetn=0 at a clock edge): time counter, din stage, din_prev, holdoff counter, FIFO pointers/count, overflow and lost counter all go to 0. m_axis_tvalid=0 and test=0 from the following cycle. Mid-operation reset flushes buffered events without emitting them.
- Stage 1 (edge k):
  - din_r <= din; din_prev <= din_r; time_r <= time counter.
  - Time counter increments every cycle and wraps from 2**TIME_WIDTH-1 to 0, with no flag on wrap.
  - The first sample after reset release carries timestamp 0.
- Hit (combinational on stage 1):
  - Level mode: vec = din_r & cfg_mask.
  - Edge mode: vec = din_r & ~din_prev & cfg_mask.
  - hit = |vec && holdoff counter == 0.
  - din_prev resets to 0, so a bit already high at the first sample after reset counts as a rising edge.
  - cfg_* changes take effect on the next hit evaluation; no pipeline flush.
- Holdoff:
  - On an accepted hit the counter loads cfg_holdoff; otherwise it decrements while nonzero.
  - A holdoff window also starts when a hit is dropped for FIFO full.
  - cfg_holdoff=N blocks exactly the next N sample cycles.
- Push (edge k+1): on hit, write {time_r, din_r} into the FIFO.
  - Accepted if count < DEPTH, or if a pop occurs in the same cycle (simultaneous push/pop when full is lossless).
  - Otherwise the event is dropped and overflow <= 1.
- Latency: din sampled at edge k appears on tdata with tvalid=1 in the cycle after edge k+1, when the FIFO was empty (2 cycles).
- AXIS rules:
  - A transfer occurs on tvalid && tready.
  - tdata and tvalid stay stable while tvalid && !tready.
  - Output order is event order; tvalid never depends on tready.
  - Every cycle with hit produces at most one word.
- Overflow: cleared by cfg_clear. If cfg_clear and a new drop happen in the same cycle, set wins.
- FIFO: pointers are FIFO_ADDR_WIDTH bits wide and wrap. Count is FIFO_ADDR_WIDTH+1 bits; full when count == DEPTH, empty when count == 0.

Optional Feature:
AXIS_TRIGGER_STAMPER_LOST_COUNT_EN
- Defined: adds output lost_count [31:0]. It increments on every dropped event and saturates at 0xFFFFFFFF. It is reset to 0 by aresetn or cfg_clear; a simultaneous drop with cfg_clear yields 1.
- Undefined: the port and counter are absent, and only the overflow flag reports loss.

Decomposition:
- Package axis_trigger_stamper_pkg holds:
  - localparams for TDATA width and FIFO depth derivation;
  - an enum for mode (MODE_LEVEL=0, MODE_EDGE=1);
  - the event word typedef {time, data}.
- One sub-module, axis_trigger_stamper_fifo: synchronous FIFO with push/pop/full/empty/count and first-word-fall-through output driving tdata/tvalid.
- Top level keeps the time counter, detection, holdoff and overflow logic.

Test Plan:
- Level mode, mask all ones, holdoff 0, tready=1; din=0x1 held for 3 cycles after reset -> 3 words with timestamps t0, t0+1, t0+2 and data 0x1; tvalid first high 2 cycles after the first sample.
- Edge mode; din 0->0x5 held for 10 cycles -> exactly one word, data 0x5. Then bit 1 added (0x7) -> one more word, data 0x7. Mask 0x4 with din toggling only bit 0 -> no words.
- cfg_holdoff=4, level mode, din=1 continuous -> accepted timestamps spaced by 5: t, t+5, t+10.
- tready=0, FIFO_ADDR_WIDTH=2, 6 distinct events -> 4 stored, overflow=1, lost_count=2 (feature on); tdata stable while stalled. Then tready=1 -> 4 words in order, tvalid drops.
- FIFO full with tready=1 and a simultaneous hit -> no drop, overflow stays 0. cfg_clear pulse coincident with a drop -> overflow=1, lost_count=1.
- TIME_WIDTH=8, run 300 cycles with periodic din -> timestamp wraps 255->0. Assert aresetn=0 mid-stream with 3 words buffered -> tvalid=0 next cycle, and the first post-reset event carries timestamp 0.
